// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES constants, the decryption sequencer FSM state type, and GF(2^8)
// helper functions used by the round primitives and the key schedule.
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES128_NR = 10;
    localparam int AES128_NK = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } dec_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = gf_mul(x, x);
        r = p;
        for (int i = 0; i < 6; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_lib.sv
// ---------------------------------------------------------------------------
// Existing AES building blocks shared with the unrolled decryptor.
//   keyExpansion  : key[32*Nk] -> fullkeys[128*(Nr+1)]; the cipher key sits in
//                   the top slice, so fullkeys[r*128 +: 128] is the key used at
//                   decryption step r (slice 0 = last encryption round key).
//   InvShiftRows  : in[128] -> out[128]
//   InvSubBytes   : in[128] -> out[128]
//   AddRKey       : a[128], b[128] -> out[128] = a ^ b
//   InvMixColumns : in[128] -> out[128]
//   DecryptRound  : in[128], key[128] -> out[128]
// Byte k of a block is bits [127-8k -: 8]; byte k is row k%4, column k/4.
// ---------------------------------------------------------------------------
module keyExpansion
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [32*Nk-1:0]      key,
    output logic [128*(Nr+1)-1:0] fullkeys
);
    localparam int NW = 4 * (Nr + 1);

    logic [31:0] w [NW];

    always_comb begin
        logic [7:0]  rc;
        logic [31:0] t;
        // NOTE: every variable driven here gets a default first so no path leaves it holding, which would infer a latch.
        rc       = 8'h01;
        t        = '0;
        fullkeys = '0;
        for (int i = 0; i < NW; i++) begin
            if (i < Nk) begin
                w[i] = key[32*(Nk-1-i) +: 32];
            end else begin
                t = w[i-1];
                if (i % Nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (Nk > 6 && i % Nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-Nk] ^ t;
            end
        end
        for (int i = 0; i < NW; i++) fullkeys[32*(NW-1-i) +: 32] = w[i];
    end
endmodule

module InvShiftRows (
    input  logic [127:0] in,
    output logic [127:0] out
);
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int SRC = r + 4 * ((c - r + 4) % 4);
            assign out[127-8*(r+4*c) -: 8] = in[127-8*SRC -: 8];
        end
    end
endmodule

module InvSubBytes
    import aes_pkg::*;
(
    input  logic [127:0] in,
    output logic [127:0] out
);
    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign out[127-8*k -: 8] = inv_sbox(in[127-8*k -: 8]);
    end
endmodule

module AddRKey (
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic [127:0] out
);
    assign out = a ^ b;
endmodule

module InvMixColumns
    import aes_pkg::*;
(
    input  logic [127:0] in,
    output logic [127:0] out
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] s0, s1, s2, s3;
        assign {s0, s1, s2, s3} = in[127-32*c -: 32];
        assign out[127-32*c -: 32] = {
            gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
            gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
            gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
    end
endmodule

module DecryptRound (
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out
);
    logic [127:0] sr, sb, ak;
    InvShiftRows  u_isr (.in(in), .out(sr));
    InvSubBytes   u_isb (.in(sr), .out(sb));
    AddRKey       u_ark (.a(sb), .b(key), .out(ak));
    InvMixColumns u_imc (.in(ak), .out(out));
endmodule

// File: rtl/aes_rkey_sel.sv
// ---------------------------------------------------------------------------
// aes_rkey_sel
// Selects one 128-bit round key out of the flattened key schedule.
//   fullkeys [128*(NR+1)] : key schedule, slice r = fullkeys[r*128 +: 128]
//   rnd      [4]          : slice index 0..NR (larger values return 0)
//   rk       [128]        : selected round key
// ---------------------------------------------------------------------------
module aes_rkey_sel
    import aes_pkg::*;
#(
    parameter int NR = AES128_NR
) (
    input  logic [128*(NR+1)-1:0] fullkeys,
    input  logic [3:0]            rnd,
    output logic [AES_BLK_W-1:0]  rk
);
    always_comb begin
        rk = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rnd == 4'(i)) rk = fullkeys[i*128 +: 128];
        end
    end
endmodule

// File: rtl/aes_decrypt_seq.sv
// ---------------------------------------------------------------------------
// aes_decrypt_seq
// Iterative AES-128 decryptor: one DecryptRound shared across rounds 1..Nr-1,
// followed by the final InvShiftRows/InvSubBytes/AddRKey step.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : ciphertext + key handshake (in[128], key[N])
//   out_valid/out_ready  : plaintext handshake (out[128])
//   busy                 : high whenever the FSM is not IDLE
//   blk_count[32]        : completed transfers, only with AES_DEC_BLKCNT_EN
// ---------------------------------------------------------------------------
module aes_decrypt_seq
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nr = AES128_NR,
    parameter int Nk = AES128_NK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in,
    input  logic [N-1:0]         key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out,
    output logic                 busy
`ifdef AES_DEC_BLKCNT_EN
    ,
    output logic [31:0]          blk_count
`endif
);
    dec_state_t state, state_nxt;

    logic [AES_BLK_W-1:0]    din_r, st_r;
    logic [N-1:0]            key_r;
    logic [3:0]              rnd_r;
    logic [3:0]              rk_idx;
    logic [128*(Nr+1)-1:0]   fullkeys;
    logic [AES_BLK_W-1:0]    rk, round_out, fin_sr, fin_sb, final_out;

    keyExpansion #(.Nk(Nk), .Nr(Nr)) u_kexp (.key(key_r), .fullkeys(fullkeys));

    aes_rkey_sel #(.NR(Nr)) u_rkey_sel (.fullkeys(fullkeys), .rnd(rk_idx), .rk(rk));

    DecryptRound u_round (.in(st_r), .key(rk), .out(round_out));

    InvShiftRows u_fin_isr (.in(st_r),   .out(fin_sr));
    InvSubBytes  u_fin_isb (.in(fin_sr), .out(fin_sb));
    AddRKey      u_fin_ark (.a(fin_sb),  .b(rk), .out(final_out));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = ROUND;
            ROUND:   if (rnd_r == 4'(Nr - 1)) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake decode plus the single round-key select shared by all steps.
    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        unique case (state)
            LOAD:    rk_idx = 4'd0;
            FINAL:   rk_idx = 4'(Nr);
            default: rk_idx = rnd_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_r <= '0;
            key_r <= '0;
            st_r  <= '0;
            rnd_r <= '0;
        end else begin
            if (in_valid && in_ready) begin
                din_r <= in;
                key_r <= key;
            end
            unique case (state)
                LOAD: begin
                    st_r  <= din_r ^ rk;
                    rnd_r <= 4'd1;
                end
                ROUND: begin
                    st_r  <= round_out;
                    rnd_r <= rnd_r + 4'd1;
                end
                FINAL:   st_r <= final_out;
                default: ;
            endcase
        end
    end

    assign out = st_r;

`ifdef AES_DEC_BLKCNT_EN
    always_ff @(posedge clk) begin
        if (rst)                         blk_count <= '0;
        else if (out_valid && out_ready) blk_count <= blk_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_seq
// Directed bench for aes_decrypt_seq: known-answer table plus backpressure,
// back-to-back, mid-operation reset, input isolation and (with
// AES_DEC_BLKCNT_EN) block counter sequences.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_seq;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] key;
        logic [127:0] pt;
    } vec_t;

    localparam int LAT = 11;  // acceptance edge to out_valid
    localparam int PER = 12;  // back-to-back spacing

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_d;
    logic [127:0] key_d;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_d;
    logic         busy;
`ifdef AES_DEC_BLKCNT_EN
    logic [31:0]  blk_count;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs [7];

    aes_decrypt_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_d),
        .key       (key_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_d),
        .busy      (busy)
`ifdef AES_DEC_BLKCNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One block with optional output stall and optional input scrambling.
    task automatic run_block(input vec_t v, input int stall, input bit scramble, input string tag);
        int n;
        bit got;
        in_valid  = 1'b1;
        in_d      = v.ct;
        key_d     = v.key;
        out_ready = (stall == 0);
        #1;
        check({tag, " in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (scramble) begin
                in_d  = {$urandom, $urandom, $urandom, $urandom};
                key_d = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
            n++;
            if (out_valid === 1'b1) got = 1'b1;
        end
        check({tag, " latency"}, n, LAT);
        check({tag, " out"}, out_d, v.pt);
        for (int s = 0; s < stall; s++) begin
            if (scramble) begin
                in_valid = 1'b1;
                in_d     = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            if (out_d !== v.pt || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                check($sformatf("%s stall%0d {out,ov,ir,busy}", tag, s),
                      {out_d[123:0], out_valid, in_ready, busy}, {v.pt[123:0], 3'b101});
            else
                n_vec++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, " done in_ready"}, in_ready, 1);
        step();
        check({tag, " post out_valid"}, out_valid, 0);
        check({tag, " post busy"}, busy, 0);
        check({tag, " post in_ready"}, in_ready, 1);
    endtask

    initial begin
        int idx, nxt, gap, idle_seen;
        bit cap;

        vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h6bc1bee22e409f96e93d7e117393172a};
        vecs[3] = '{128'hf5d3d58503b9699de785895a96fdbaaf, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51};
        vecs[4] = '{128'h43b1cd7f598ece23881b00e3ed030688, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h30c81c46a35ce411e5fbc1191a0a52ef};
        vecs[5] = '{128'h7b0c785e27e8ad3f8223207104725dd4, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'hf69f2445df4f9b17ad2b417be66c3710};
        vecs[6] = '{128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0,
                    128'h0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_d      = '0;
        key_d     = '0;
        out_ready = 1'b0;
        step();
        step();
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out", out_d, 0);
`ifdef AES_DEC_BLKCNT_EN
        check("reset blk_count", blk_count, 0);
`endif
        rst = 1'b0;
        step();
        check("idle in_ready", in_ready, 1);
        check("idle busy", busy, 0);

        // Known-answer table, out_ready held high.
        for (int i = 0; i < 7; i++) run_block(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));

        // Backpressure: 20 stalled cycles in DONE.
        run_block(vecs[0], 20, 1'b0, "bp");

        // Input isolation: in/key scrambled every cycle after acceptance.
        run_block(vecs[1], 3, 1'b1, "iso");

        // Back-to-back: in_valid held high, four distinct blocks.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_d      = vecs[2].ct;
        key_d     = vecs[2].key;
        step();
        nxt       = 1;
        in_d      = vecs[3].ct;
        key_d     = vecs[3].key;
        idx       = 0;
        gap       = 0;
        idle_seen = 0;
        cap       = 1'b0;
        while (idx < 4 && gap < 40) begin
            step();
            gap++;
            if (cap) begin
                nxt++;
                if (nxt < 4) begin
                    in_d  = vecs[2+nxt].ct;
                    key_d = vecs[2+nxt].key;
                end
                cap = 1'b0;
            end
            if (busy !== 1'b1) idle_seen++;
            if (out_valid === 1'b1) begin
                check($sformatf("b2b%0d spacing", idx), gap, (idx == 0) ? LAT : PER);
                check($sformatf("b2b%0d out", idx), out_d, vecs[2+idx].pt);
                idx++;
                gap = 0;
                if (idx < 4) begin
                    check($sformatf("b2b%0d in_ready", idx), in_ready, 1);
                    cap = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b blocks seen", idx, 4);
        check("b2b idle cycles", idle_seen, 0);
        step();
        check("b2b end busy", busy, 0);

        // Reset in ROUND with rnd_r = 5.
        in_valid  = 1'b1;
        in_d      = vecs[0].ct;
        key_d     = vecs[0].key;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("midrst busy before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst out_valid", out_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst in_ready", in_ready, 1);
        check("midrst out", out_d, 0);
        run_block(vecs[0], 0, 1'b0, "after_rst");

`ifdef AES_DEC_BLKCNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cnt cleared", blk_count, 0);
        run_block(vecs[0], 0, 1'b0, "cnt1");
        check("cnt after 1", blk_count, 1);
        run_block(vecs[1], 6, 1'b0, "cnt2");
        check("cnt after 2 (stalled)", blk_count, 2);
        run_block(vecs[6], 0, 1'b0, "cnt3");
        check("cnt after 3", blk_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("cnt after rst", blk_count, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
